// File: rtl/issue_scoreboard_mc.sv
// Pending-write scoreboard with a saturating counter per architectural register.
// Optional macro SCOREBOARD_CMPL_BYPASS_EN: hazards see same-cycle completions.
module issue_scoreboard_mc #(
  parameter int P_NUM_REGS  = 32,
  parameter int P_ADDR_BITS = 5,
  parameter int P_CNT_BITS  = 2,
  parameter int P_NUM_SRCS  = 2,
  parameter int P_NUM_CMPL  = 1,
  localparam int CNT_MAX    = 2**P_CNT_BITS - 1,
  localparam int TOT_W      = $clog2(P_NUM_REGS*CNT_MAX + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [P_NUM_SRCS*P_ADDR_BITS-1:0] src_addr,
  input  logic [P_NUM_SRCS-1:0]             src_en,
  input  logic [P_ADDR_BITS-1:0]            dst_addr,
  input  logic                              dst_en,
  input  logic                              issue,
  input  logic [P_NUM_CMPL-1:0]             cmpl_val,
  input  logic [P_NUM_CMPL*P_ADDR_BITS-1:0] cmpl_addr,
  input  logic [P_NUM_CMPL-1:0]             cmpl_wen,
  output logic                              raw_hazard,
  output logic                              waw_full,
  output logic [P_NUM_REGS-1:0]             pending_vec,
  output logic [TOT_W-1:0]                  total_pending,
  output logic                              err
);

  // Handshake: issue is the router transfer strobe; the issue unit qualifies its
  // valid with !raw_hazard & !waw_full, and neither output looks at issue.

  logic [P_CNT_BITS-1:0] cnt_q   [P_NUM_REGS];
  logic [P_CNT_BITS-1:0] cnt_d   [P_NUM_REGS];
  logic [P_CNT_BITS-1:0] eff_cnt [P_NUM_REGS];
  int                    dec     [P_NUM_REGS];
  logic [TOT_W-1:0]      total_pending_q, total_pending_d;
  logic                  err_q, err_d;
  logic                  inc;
  int                    sum_v;
  int                    eff_v;
  int                    tot_v;

  // Decode completions into per-register decrement counts; r=0 never matches.
  always_comb begin
    for (int r = 0; r < P_NUM_REGS; r++) begin
      dec[r] = 0;
      for (int j = 0; j < P_NUM_CMPL; j++) begin
        if (r != 0 && cmpl_val[j] && cmpl_wen[j] &&
            cmpl_addr[j*P_ADDR_BITS +: P_ADDR_BITS] == P_ADDR_BITS'(r))
          dec[r] = dec[r] + 1;
      end
    end
  end

  // Counter next state with underflow clamp and overflow drop.
  always_comb begin
    err_d = err_q;
    tot_v = 0;
    sum_v = 0;
    for (int r = 0; r < P_NUM_REGS; r++) begin
      inc   = (r != 0) && issue && dst_en && (dst_addr == P_ADDR_BITS'(r));
      sum_v = int'(cnt_q[r]) + (inc ? 1 : 0) - dec[r];
      if (sum_v < 0) begin
        cnt_d[r] = '0;
        err_d    = 1'b1;
      end else if (sum_v > CNT_MAX) begin
        cnt_d[r] = cnt_q[r];
        err_d    = 1'b1;
      end else begin
        cnt_d[r] = P_CNT_BITS'(sum_v);
      end
      tot_v = tot_v + int'(cnt_d[r]);
    end
    total_pending_d = TOT_W'(tot_v);
  end

  // Count seen by the hazard checks.
  always_comb begin
    eff_v = 0;
    for (int r = 0; r < P_NUM_REGS; r++) begin
`ifdef SCOREBOARD_CMPL_BYPASS_EN
      eff_v = int'(cnt_q[r]) - dec[r];
`else
      eff_v = int'(cnt_q[r]);
`endif
      eff_cnt[r] = (eff_v < 0) ? '0 : P_CNT_BITS'(eff_v);
    end
  end

  always_comb begin
    raw_hazard = 1'b0;
    waw_full   = 1'b0;
    for (int r = 1; r < P_NUM_REGS; r++) begin
      for (int i = 0; i < P_NUM_SRCS; i++) begin
        if (src_en[i] && src_addr[i*P_ADDR_BITS +: P_ADDR_BITS] == P_ADDR_BITS'(r) &&
            eff_cnt[r] != '0)
          raw_hazard = 1'b1;
      end
      if (dst_en && dst_addr == P_ADDR_BITS'(r) && int'(eff_cnt[r]) == CNT_MAX)
        waw_full = 1'b1;
    end
    // Stale pre-reset state must not leak out while rst is held.
    if (rst) begin
      raw_hazard = 1'b0;
      waw_full   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < P_NUM_REGS; r++) cnt_q[r] <= '0;
      total_pending_q <= '0;
      err_q           <= 1'b0;
    end else begin
      for (int r = 0; r < P_NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
      total_pending_q <= total_pending_d;
      err_q           <= err_d;
    end
  end

  always_comb begin
    for (int r = 0; r < P_NUM_REGS; r++) pending_vec[r] = (cnt_q[r] != '0);
  end

  assign total_pending = total_pending_q;
  assign err           = err_q;

endmodule

// File: doc/issue_scoreboard_mc.md
Name: issue_scoreboard_mc

Overview:
- Parametrised pending-write scoreboard for the decode/issue stage.
- Each architectural register has a pending-write counter instead of a single pending bit. WAW issue is therefore allowed up to a per-register depth; RAW still stalls.
- Supports multiple source-check ports and multiple completion ports per cycle.
- Sits between the decoder and the instruction router. The issue unit ANDs its valid with `!raw_hazard & !waw_full`.

Parameters:
- P_NUM_REGS, 32, number of architectural registers; register 0 is hardwired, never pending.
- P_ADDR_BITS, 5, register address width; must satisfy 2^P_ADDR_BITS >= P_NUM_REGS.
- P_CNT_BITS, 2, per-register counter width; max outstanding writes per register = 2^P_CNT_BITS-1.
- P_NUM_SRCS, 2, number of source-operand check ports.
- P_NUM_CMPL, 1, number of completion ports processed per cycle.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- src_addr  in  P_NUM_SRCS*P_ADDR_BITS  source register addresses; port i is bits [i*P_ADDR_BITS +: P_ADDR_BITS].
- src_en  in  P_NUM_SRCS  per-source enable (operand actually read).
- dst_addr  in  P_ADDR_BITS  destination of the instruction being checked/issued.
- dst_en  in  1  instruction writes a register.
- issue  in  1  instruction issued this cycle (router xfer).
- cmpl_val  in  P_NUM_CMPL  completion valid per port.
- cmpl_addr  in  P_NUM_CMPL*P_ADDR_BITS  completion write address per port.
- cmpl_wen  in  P_NUM_CMPL  completion actually writes a register.
- raw_hazard  out  1  some enabled source has a pending write.
- waw_full  out  1  destination counter is saturated.
- pending_vec  out  P_NUM_REGS  bit r = (cnt[r] != 0).
- total_pending  out  $clog2(P_NUM_REGS*(2^P_CNT_BITS-1)+1)  sum of all counters.
- err  out  1  sticky protocol error.

Behaviour:
- Reset: all cnt[r]=0, total_pending=0, err=0, pending_vec=0. Outputs raw_hazard and waw_full evaluate to 0 for any input.
- Reset mid-operation discards all outstanding state. Completions arriving after reset for pre-reset issues are underflows and set err.

Hazard outputs (combinational from current state and inputs):
- raw_hazard = OR over i of (src_en[i] & src_addr[i]!=0 & cnt[src_addr[i]]!=0).
- waw_full = dst_en & dst_addr!=0 & cnt[dst_addr]==2^P_CNT_BITS-1.
- Neither output depends on issue, so there is no combinational loop through the router.

Counter update (registered, one edge):
- Increment term: inc = issue & dst_en & dst_addr!=0.
- Decrement term: dec[r] = number of ports j with cmpl_val[j] & cmpl_wen[j] & cmpl_addr[j]==r, r!=0.
- Next value: cnt[r]' = cnt[r] + inc(r) - dec[r], all terms applied in the same cycle.
- Issue and completion to the same register in the same cycle leave cnt unchanged, including when cnt is saturated or 0.
- Underflow (computed next value < 0): clamp cnt[r] to 0 and set err.
- Overflow (issue while waw_full): the increment is dropped, the counter holds, and err is set. The issue is still counted if a same-cycle completion frees a slot.
- Writes or completions addressed to register 0, or with address >= P_NUM_REGS, are ignored with no err.
- total_pending is updated in the same cycle by the net of applied increments and decrements. It always equals the sum of cnt[r].
- err is sticky until rst.
- Latency: a pending state set by issue in cycle N is visible on raw_hazard in cycle N+1. A completion in cycle N clears the hazard in N+1 unless bypass is enabled.

Optional Feature:
- Macro: SCOREBOARD_CMPL_BYPASS_EN.
- Defined: raw_hazard and waw_full use the effective count cnt[r] - dec[r] (floored at 0). A completion in cycle N releases a dependent source in the same cycle N. The register-file write-through is assumed in the same cycle. pending_vec still reflects registered state.
- Undefined: hazards use registered cnt only, giving a one-cycle release delay.

Test Plan:
- Reset, then src_addr={x2,x1}, src_en=2'b11 -> raw_hazard=0, waw_full=0, total_pending=0, err=0.
- Issue dst x5 in 3 consecutive cycles (P_CNT_BITS=2) -> cnt[5]=3, waw_full=1 with dst_addr=5, pending_vec[5]=1, total_pending=3. A fourth issue sets err=1 with cnt held at 3.
- cnt[7]=1; src0=x7 -> raw_hazard=1. Complete x7 in cycle N -> without macro raw_hazard=1 in N and 0 in N+1; with macro 0 in N.
- cnt[3]=1; issue dst x3 and complete x3 same cycle -> cnt[3] stays 1, total_pending unchanged, err=0.
- P_NUM_CMPL=2, cnt[4]=2; both ports complete x4 same cycle -> cnt[4]=0, total_pending drops by 2. Repeat with cnt[4]=1 -> cnt[4]=0, err=1.
- Issue to x0 and complete x0 -> no state change, raw_hazard=0 for src x0. Assert rst with 5 pending -> all counters and err return to 0 the next cycle.
